cs_resolve_acc: RTL and testbench

CS_RESOLVE_ACC -- requirements
Module: cs_resolve_acc

---
 rtl/ai_core_pkg.sv | 21 ++
 rtl/cs_sat_add.sv | 50 +++++
 rtl/cs_resolve_acc.sv | 122 ++++++++++++
 tb/tb_cs_resolve_acc.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/ai_core_pkg.sv
// ai_core_pkg
//   Shared definitions for the MAC-array result path.
//   - state_e      : resolve/accumulate FSM states (ACC, DONE)
//   - IN_SIZE_DEF  : width of one redundant (sum or carry) word leaving the MAC array
//   - ACC_SIZE_DEF : default frame accumulator width
package ai_core_pkg;

  // MAC array geometry: 8x8 signed products summed over 16 taps.
  localparam int MAC_OPERAND_W = 8;
  localparam int MAC_TAPS      = 16;

  // A product is 2*operand bits. Summing 16 taps adds log2(16) = 4 growth bits.
  localparam int IN_SIZE_DEF   = 2 * MAC_OPERAND_W + $clog2(MAC_TAPS);
  localparam int ACC_SIZE_DEF  = 32;

  typedef enum logic {
    ACC  = 1'b0,
    DONE = 1'b1
  } state_e;

endpackage

// File: rtl/cs_sat_add.sv
// cs_sat_add
//   Three-operand signed add: res = acc + sext(sum) + sext(carry).
//   The two redundant words are resolved into one term before the
//   accumulator add, so overflow is judged only on the final add.
//   Optional feature macro: SATURATE_EN
//     defined   : clamp to the signed extremes on overflow, ovf_o flags it
//     undefined : wrap modulo 2^ACC_SIZE, ovf_o tied 0
// Ports
//   acc_i   in  ACC_SIZE  signed running accumulator
//   sum_i   in  IN_SIZE   signed redundant word 0
//   carry_i in  IN_SIZE   signed redundant word 1
//   res_o   out ACC_SIZE  signed result
//   ovf_o   out 1         signed overflow of this add
module cs_sat_add #(
  parameter int IN_SIZE  = 20,
  parameter int ACC_SIZE = 32
) (
  input  logic signed [ACC_SIZE-1:0] acc_i,
  input  logic signed [IN_SIZE-1:0]  sum_i,
  input  logic signed [IN_SIZE-1:0]  carry_i,
  output logic signed [ACC_SIZE-1:0] res_o,
  output logic                       ovf_o
);

  function automatic logic signed [ACC_SIZE-1:0] sext(input logic signed [IN_SIZE-1:0] v);
    return {{(ACC_SIZE-IN_SIZE){v[IN_SIZE-1]}}, v};
  endfunction

  // The sum of two IN_SIZE words needs IN_SIZE+1 bits, which fits in ACC_SIZE.
  logic signed [ACC_SIZE-1:0] term;
  assign term = sext(sum_i) + sext(carry_i);

`ifdef SATURATE_EN
  // Largest positive value for neg=0, most negative value for neg=1.
  function automatic logic signed [ACC_SIZE-1:0] sat_limit(input logic neg);
    return {neg, {(ACC_SIZE-1){~neg}}};
  endfunction

  // One guard bit: overflow when the guard and the result sign disagree;
  // the guard holds the true sign of the result.
  logic signed [ACC_SIZE:0] wide;
  assign wide  = {acc_i[ACC_SIZE-1], acc_i} + {term[ACC_SIZE-1], term};
  assign ovf_o = wide[ACC_SIZE] ^ wide[ACC_SIZE-1];
  assign res_o = ovf_o ? sat_limit(wide[ACC_SIZE]) : wide[ACC_SIZE-1:0];
`else
  assign res_o = acc_i + term;
  assign ovf_o = 1'b0;
`endif

endmodule

// File: rtl/cs_resolve_acc.sv
// cs_resolve_acc
//   Accumulates a frame of carry-save beats from the MAC array into one
//   signed result. It presents the result with a valid/ready handshake.
//   The FSM has two states. ACC accepts beats. DONE holds the result until
//   the consumer takes it.
//   Optional feature macro: SATURATE_EN (clamp plus sticky overflow flag).
// Ports
//   clk_i        in   1         clock, rising edge
//   rst_ni       in   1         asynchronous active-low reset
//   clear_i      in   1         synchronous frame abort (beats over handshakes)
//   in_valid_i   in   1         beat valid
//   in_ready_o   out  1         beat accepted (state ACC)
//   in_sum_i     in   IN_SIZE   signed redundant word 0
//   in_carry_i   in   IN_SIZE   signed redundant word 1
//   in_last_i    in   1         beat closes the frame
//   out_valid_o  out  1         result valid (state DONE)
//   out_ready_i  in   1         consumer takes the result
//   out_data_o   out  ACC_SIZE  signed accumulator (partial while in ACC)
//   out_beats_o  out  BEAT_SIZE beat count, saturating at all-ones
//   out_ovf_o    out  1         frame saturated (0 without SATURATE_EN)
module cs_resolve_acc
  import ai_core_pkg::*;
#(
  parameter int IN_SIZE   = IN_SIZE_DEF,
  parameter int ACC_SIZE  = ACC_SIZE_DEF,
  parameter int BEAT_SIZE = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 clear_i,
  input  logic                 in_valid_i,
  output logic                 in_ready_o,
  input  logic [IN_SIZE-1:0]   in_sum_i,
  input  logic [IN_SIZE-1:0]   in_carry_i,
  input  logic                 in_last_i,
  output logic                 out_valid_o,
  input  logic                 out_ready_i,
  output logic [ACC_SIZE-1:0]  out_data_o,
  output logic [BEAT_SIZE-1:0] out_beats_o,
  output logic                 out_ovf_o
);

  state_e                     state_q;
  logic signed [ACC_SIZE-1:0] acc_q, acc_d;
  logic [BEAT_SIZE-1:0]       beats_q, beats_d;
  logic                       add_ovf;

  cs_sat_add #(
    .IN_SIZE  (IN_SIZE),
    .ACC_SIZE (ACC_SIZE)
  ) u_add (
    .acc_i   (acc_q),
    .sum_i   (in_sum_i),
    .carry_i (in_carry_i),
    .res_o   (acc_d),
    .ovf_o   (add_ovf)
  );

  // The counter sticks at all-ones so a long frame never reads as a short one.
  assign beats_d = (&beats_q) ? beats_q : beats_q + 1'b1;

`ifdef SATURATE_EN
  logic ovf_q;
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ACC;
      acc_q   <= '0;
      beats_q <= '0;
`ifdef SATURATE_EN
      ovf_q   <= 1'b0;
`endif
    end else if (clear_i) begin
      // The abort wins over any handshake in the same cycle.
      state_q <= ACC;
      acc_q   <= '0;
      beats_q <= '0;
`ifdef SATURATE_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      unique case (state_q)
        ACC: begin
          if (in_valid_i) begin
            acc_q   <= acc_d;
            beats_q <= beats_d;
`ifdef SATURATE_EN
            ovf_q   <= ovf_q | add_ovf;
`endif
            if (in_last_i) state_q <= DONE;
          end
        end
        DONE: begin
          // Start the next frame from zero on the same edge as the result handshake.
          if (out_ready_i) begin
            state_q <= ACC;
            acc_q   <= '0;
            beats_q <= '0;
`ifdef SATURATE_EN
            ovf_q   <= 1'b0;
`endif
          end
        end
        default: state_q <= ACC;
      endcase
    end
  end

  // The handshake outputs decode only the state register, so there is no
  // combinational path from any input.
  assign in_ready_o  = (state_q == ACC);
  assign out_valid_o = (state_q == DONE);
  assign out_data_o  = acc_q;
  assign out_beats_o = beats_q;
`ifdef SATURATE_EN
  assign out_ovf_o   = ovf_q;
`else
  assign out_ovf_o   = add_ovf;  // constant 0 from the adder in this build
`endif

endmodule

// File: tb/tb_cs_resolve_acc.sv
// Testbench for cs_resolve_acc (IN_SIZE=20, ACC_SIZE=24, BEAT_SIZE=3).
// The overflow expectations follow the SATURATE_EN macro.
module tb_cs_resolve_acc;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        clear;
  logic        in_valid;
  logic        in_ready;
  logic [19:0] in_sum;
  logic [19:0] in_carry;
  logic        in_last;
  logic        out_valid;
  logic        out_ready;
  logic [23:0] out_data;
  logic [2:0]  out_beats;
  logic        out_ovf;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  cs_resolve_acc #(
    .IN_SIZE   (20),
    .ACC_SIZE  (24),
    .BEAT_SIZE (3)
  ) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .clear_i     (clear),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready),
    .in_sum_i    (in_sum),
    .in_carry_i  (in_carry),
    .in_last_i   (in_last),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .out_data_o  (out_data),
    .out_beats_o (out_beats),
    .out_ovf_o   (out_ovf)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One beat is driven from the falling edge. Results are sampled 1 ns after the rising edge.
  task automatic beat(input int s, input int c, input logic l);
    @(negedge clk);
    in_valid = 1'b1;
    in_sum   = s[19:0];
    in_carry = c[19:0];
    in_last  = l;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic ack();
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check("ack_valid", 32'(out_valid), 32'd0);
    check("ack_data",  32'(out_data),  32'd0);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_ready"}, 32'(in_ready),  32'd1);
    check({tag, "_valid"}, 32'(out_valid), 32'd0);
    check({tag, "_data"},  32'(out_data),  32'd0);
    check({tag, "_beats"}, 32'(out_beats), 32'd0);
    check({tag, "_ovf"},   32'(out_ovf),   32'd0);
  endtask

  logic [23:0] exp_big;
  logic        exp_ovf;

  initial begin
    rst_n = 1'b0; clear = 1'b0; in_valid = 1'b0; in_sum = '0; in_carry = '0;
    in_last = 1'b0; out_ready = 1'b0;
    #12;
    check_reset_vals("rst");
    @(negedge clk);
    rst_n = 1'b1;

    // Single beat: 5 + (-3) = 2
    beat(5, 32'h000FFFFD, 1'b1);
    check("one_valid", 32'(out_valid), 32'd1);
    check("one_ready", 32'(in_ready),  32'd0);
    check("one_data",  32'(out_data),  32'd2);
    check("one_beats", 32'(out_beats), 32'd1);
    ack();
    check("one_back_ready", 32'(in_ready), 32'd1);

    // Three beats with out_ready held high: 100 - 30 + 0 = 70
    out_ready = 1'b1;
    beat(100, 0, 1'b0);
    beat(-50, 20, 1'b0);
    check("three_part_data",  32'(out_data),  32'd70);
    check("three_part_beats", 32'(out_beats), 32'd2);
    beat(7, -7, 1'b1);
    check("three_valid", 32'(out_valid), 32'd1);
    check("three_data",  32'(out_data),  32'd70);
    check("three_beats", 32'(out_beats), 32'd3);
    @(posedge clk); #1;
    check("three_acc_again", 32'(out_valid), 32'd0);
    check("three_ready",     32'(in_ready),  32'd1);
    out_ready = 1'b0;

    // Backpressure: the result holds for 5 cycles, then a beat is taken one cycle after release.
    beat(3, 4, 1'b1);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check("bp_valid", 32'(out_valid), 32'd1);
      check("bp_data",  32'(out_data),  32'd7);
      check("bp_ready", 32'(in_ready),  32'd0);
    end
    @(negedge clk);
    out_ready = 1'b1; in_valid = 1'b1; in_sum = 20'd1; in_carry = 20'd0; in_last = 1'b1;
    @(posedge clk); #1;
    check("rel_valid", 32'(out_valid), 32'd0);
    check("rel_beats", 32'(out_beats), 32'd0);
    out_ready = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0; in_last = 1'b0;
    check("rel_take_valid", 32'(out_valid), 32'd1);
    check("rel_take_data",  32'(out_data),  32'd1);
    check("rel_take_beats", 32'(out_beats), 32'd1);
    ack();

    // Ten beats of 2*0x7FFFF into 24 bits; the beat count sticks at 7.
    for (int i = 0; i < 10; i++) begin
      beat(32'h7FFFF, 32'h7FFFF, (i == 9));
      if (i == 7) begin
        check("big_part_data", 32'(out_data), 32'h7FFFF0);  // 8 * 1048574
        check("big_part_ovf",  32'(out_ovf),  32'd0);
      end
    end
`ifdef SATURATE_EN
    exp_big = 24'h7FFFFF;
    exp_ovf = 1'b1;
`else
    exp_big = 24'h9FFFEC;  // 10485740 mod 2^24 = -6291476
    exp_ovf = 1'b0;
`endif
    check("big_valid", 32'(out_valid), 32'd1);
    check("big_data",  32'(out_data),  32'(exp_big));
    check("big_ovf",   32'(out_ovf),   32'(exp_ovf));
    check("big_beats", 32'(out_beats), 32'd7);
    ack();
    check("big_ovf_cleared", 32'(out_ovf), 32'd0);

    // The clear drops a simultaneous beat.
    beat(10, 0, 1'b0);
    beat(10, 0, 1'b0);
    check("clr_part_data", 32'(out_data), 32'd20);
    @(negedge clk);
    clear = 1'b1; in_valid = 1'b1; in_sum = 20'd10; in_carry = 20'd0;
    @(posedge clk); #1;
    clear = 1'b0; in_valid = 1'b0;
    check("clr_data",  32'(out_data),  32'd0);
    check("clr_beats", 32'(out_beats), 32'd0);
    beat(5, 0, 1'b1);
    check("clr_next_data",  32'(out_data),  32'd5);
    check("clr_next_beats", 32'(out_beats), 32'd1);
    // A clear in DONE discards the result even with out_ready high.
    @(negedge clk);
    clear = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0; out_ready = 1'b0;
    check("clr_done_valid", 32'(out_valid), 32'd0);
    check("clr_done_data",  32'(out_data),  32'd0);

    // An asynchronous reset mid-frame and in DONE takes effect without a clock edge.
    beat(9, 0, 1'b0);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_reset_vals("rst_mid");
    @(negedge clk);
    rst_n = 1'b1;
    beat(3, 0, 1'b1);
    check("pre_rst_done_valid", 32'(out_valid), 32'd1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_reset_vals("rst_done");
    @(negedge clk);
    rst_n = 1'b1;
    beat(4, 0, 1'b1);
    check("post_rst_data",  32'(out_data),  32'd4);
    check("post_rst_beats", 32'(out_beats), 32'd1);
    ack();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
